// File: rtl/free_list.sv
// Physical-register free list for rename: circular FIFO with a speculative head
// (dispatch), an architectural head (retirement) and a tail (frees from retirement).
module free_list #(
   parameter int PHYS_REG_SZ = 64,
   parameter int PR_W        = $clog2(PHYS_REG_SZ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc_req,
   output logic            alloc_valid,
   output logic [PR_W-1:0] alloc_pr,
   input  logic            retire_enable,
   input  logic [PR_W-1:0] retire_old_pr,
   input  logic            restore_enable,
   output logic [PR_W:0]   free_count,
   output logic            overflow_err
);

   localparam int PTR_W = PR_W + 1;

   logic [PR_W-1:0]  pr_buf [PHYS_REG_SZ];
   logic [PTR_W-1:0] head, arch_head, tail;
   logic [PTR_W-1:0] arch_head_next, occupancy;
   logic             full, do_alloc, do_push, push_req;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      free_count     = tail - head;
      alloc_valid    = (free_count != '0);
      alloc_pr       = pr_buf[head[PR_W-1:0]];
      occupancy      = tail - arch_head;
      full           = (occupancy == PTR_W'(PHYS_REG_SZ));
      arch_head_next = arch_head + (retire_enable ? PTR_W'(1) : PTR_W'(0));
      do_alloc       = alloc_req && alloc_valid && !restore_enable;
      push_req       = retire_enable && (retire_old_pr != '0);
      do_push        = push_req && !full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // PR 0 is the hard-wired initial mapping and never lives on the list.
         for (int i = 0; i < PHYS_REG_SZ; i++)
            pr_buf[i] <= PR_W'(i + 1);
         head         <= '0;
         arch_head    <= '0;
         tail         <= PTR_W'(PHYS_REG_SZ - 1);
         overflow_err <= 1'b0;
      end else begin
         if (do_push) begin
            pr_buf[tail[PR_W-1:0]] <= retire_old_pr;
            tail                   <= tail + PTR_W'(1);
         end
         if (push_req && full)
            overflow_err <= 1'b1;
         arch_head <= arch_head_next;
         if (restore_enable)
            head <= arch_head_next;
         else if (do_alloc)
            head <= head + PTR_W'(1);
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based behavioural model feeds an
// expected-output scoreboard that each scenario drains after every clock.
module tb_free_list;

   localparam int N = 64;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         alloc_req;
   logic         alloc_valid;
   logic [W-1:0] alloc_pr;
   logic         retire_enable;
   logic [W-1:0] retire_old_pr;
   logic         restore_enable;
   logic [W:0]   free_count;
   logic         overflow_err;

   free_list #(.PHYS_REG_SZ(N)) dut (
      .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
      .alloc_pr(alloc_pr), .retire_enable(retire_enable), .retire_old_pr(retire_old_pr),
      .restore_enable(restore_enable), .free_count(free_count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         v;
      logic [W-1:0] pr;
      logic [W:0]   cnt;
      logic         ovf;
   } obs_t;

   // Model: fl holds every entry from the architectural head to the tail,
   // nspec counts speculative allocations not yet retired.
   logic [W-1:0] fl [$];
   int           nspec;
   logic         m_ovf;
   obs_t         exp_q [$];
   int           checks = 0;
   int           passes = 0;

   task automatic model_reset();
      fl.delete();
      for (int i = 1; i < N; i++) fl.push_back(W'(i));
      nspec = 0;
      m_ovf = 1'b0;
   endtask

   function automatic obs_t model_out();
      obs_t e;
      int   avail;
      avail = fl.size() - nspec;
      e.v   = (avail != 0);
      e.pr  = e.v ? fl[nspec] : '0;
      e.cnt = (W+1)'(avail);
      e.ovf = m_ovf;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.v   = alloc_valid;
      o.pr  = alloc_valid ? alloc_pr : '0;
      o.cnt = free_count;
      o.ovf = overflow_err;
      return o;
   endfunction

   // Drive one cycle of stimulus, advance the model and queue the expected outputs.
   task automatic step(input bit a, input bit r, input logic [W-1:0] old,
                       input bit rs, input bit rst = 1'b0);
      reset = rst; alloc_req = a; retire_enable = r; retire_old_pr = old; restore_enable = rs;
      if (rst) model_reset();
      else begin
         if (a && !rs && (fl.size() - nspec) > 0) nspec++;
         if (r) begin
            if (old != '0) begin
               if (fl.size() == N) m_ovf = 1'b1;
               else fl.push_back(old);
            end
            void'(fl.pop_front());
            if (nspec > 0) nspec--;
         end
         if (rs) nspec = 0;
      end
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      reset = 1'b0; alloc_req = 1'b0; retire_enable = 1'b0; retire_old_pr = '0; restore_enable = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o, e;
      step(1'b1, 1'b1, 6'd9, 1'b1, 1'b1);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL reset got %h expected %h", o, e); else passes++;
      checks++;
      if (free_count !== 7'd63 || alloc_valid !== 1'b1 || alloc_pr !== 6'd1 || overflow_err !== 1'b0)
         $display("FAIL reset_const got cnt=%0d v=%b pr=%0d ovf=%b expected 63/1/1/0",
                  free_count, alloc_valid, alloc_pr, overflow_err);
      else passes++;
   endtask

   task automatic test_drain();
      obs_t o, e;
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         o = sample(); e = exp_q.pop_front(); checks++;
         if (o !== e) $display("FAIL drain cyc%0d got %h expected %h", i, o, e); else passes++;
      end
      checks++;
      if (alloc_valid !== 1'b0 || free_count !== '0)
         $display("FAIL drain_empty got v=%b cnt=%0d expected 0/0", alloc_valid, free_count);
      else passes++;
   endtask

   task automatic test_free_from_empty();
      obs_t o, e;
      step(1'b0, 1'b1, 6'd5, 1'b0);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL free5 got %h expected %h", o, e); else passes++;
      checks++;
      if (alloc_valid !== 1'b1 || alloc_pr !== 6'd5 || free_count !== 7'd1)
         $display("FAIL free5_const got v=%b pr=%0d cnt=%0d expected 1/5/1", alloc_valid, alloc_pr, free_count);
      else passes++;
      step(1'b0, 1'b1, 6'd0, 1'b0);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL free0 got %h expected %h", o, e); else passes++;
   endtask

   task automatic test_restore();
      obs_t o, e;
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, 6'd0, 1'b0);
      repeat (4) void'(exp_q.pop_front());
      step(1'b1, 1'b0, '0, 1'b1);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL restore got %h expected %h", o, e); else passes++;
      checks++;
      if (alloc_pr !== 6'd2 || free_count !== 7'd62)
         $display("FAIL restore_const got pr=%0d cnt=%0d expected 2/62", alloc_pr, free_count);
      else passes++;
      step(1'b1, 1'b0, '0, 1'b0);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL restore_next got %h expected %h", o, e); else passes++;
   endtask

   task automatic test_restore_retire();
      obs_t o, e;
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      repeat (3) void'(exp_q.pop_front());
      step(1'b0, 1'b1, 6'd0, 1'b1);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL rst_ret got %h expected %h", o, e); else passes++;
      checks++;
      if (alloc_pr !== 6'd2 || free_count !== 7'd62)
         $display("FAIL rst_ret_const got pr=%0d cnt=%0d expected 2/62", alloc_pr, free_count);
      else passes++;
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      int   errs = 0;
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b1, 6'd7, 1'b0);
         o = sample(); e = exp_q.pop_front();
         if (o !== e) begin
            errs++;
            if (errs < 5) $display("FAIL b2b cyc%0d got %h expected %h", i, o, e);
         end
         if (i == 62) begin
            checks++;
            if (alloc_pr !== 6'd7 || free_count !== 7'd63)
               $display("FAIL b2b_lap got pr=%0d cnt=%0d expected 7/63", alloc_pr, free_count);
            else passes++;
         end
      end
      checks++;
      if (errs != 0) $display("FAIL b2b_seq got %0d bad cycles expected 0", errs); else passes++;
      checks++;
      if (overflow_err !== 1'b0 || free_count !== 7'd63)
         $display("FAIL b2b_end got ovf=%b cnt=%0d expected 0/63", overflow_err, free_count);
      else passes++;
   endtask

   task automatic test_mid_reset();
      obs_t o, e;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
      repeat (5) void'(exp_q.pop_front());
      step(1'b1, 1'b1, 6'd3, 1'b0, 1'b1);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) $display("FAIL mid_reset got %h expected %h", o, e); else passes++;
   endtask

   initial begin
      reset = 1'b1; alloc_req = 1'b0; retire_enable = 1'b0; retire_old_pr = '0; restore_enable = 1'b0;
      model_reset();
      #1;
      test_reset();
      test_drain();
      test_free_from_empty();
      test_restore();
      test_restore_retire();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage: the producer of new destination physical registers consumed by the map table at dispatch, and the sink for old destination registers released at retirement. It is a circular FIFO with a speculative head (dispatch), an architectural head (retirement) and a tail (frees). On restore (mispredict recovery) the speculative head snaps back to the architectural head, matching the map table's copy of retired mappings.

## Interface
- PHYS_REG_SZ, 64, number of physical registers; PR 0 is the hard-wired zero/initial register and is never placed on the list
- PR_W, $clog2(PHYS_REG_SZ), physical register index width
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- alloc_req  input  1  dispatch takes one PR this cycle (instruction with non-zero arch dest)
- alloc_valid  output  1  list non-empty; alloc_pr is valid
- alloc_pr  output  PR_W  PR at speculative head
- retire_enable  input  1  retiring instruction with non-zero arch dest
- retire_old_pr  input  PR_W  old dest PR of retiring instruction, to be freed
- restore_enable  input  1  squash: discard all speculative allocations
- free_count  output  PR_W+1  number of PRs currently allocatable
- overflow_err  output  1  sticky: push attempted while buffer full

## Operation
- Storage: buf[0..PHYS_REG_SZ-1] of PR_W bits; pointers head, arch_head, tail each PR_W+1 bits (extra wrap bit); slot index = pointer[PR_W-1:0].
- free_count = tail - head (PR_W+1-bit modular subtraction); alloc_valid = (free_count != 0); alloc_pr = buf[head slot].
- Allocate: alloc_req && alloc_valid -> head <= head+1. alloc_req with !alloc_valid is ignored (no pointer change).
- Retire: retire_enable -> arch_head <= arch_head+1. If retire_old_pr != 0: buf[tail slot] <= retire_old_pr, tail <= tail+1. retire_old_pr == 0 is not pushed (initial mapping).
- Full: tail - arch_head == PHYS_REG_SZ. Push while full: push dropped, overflow_err <= 1 (until reset), arch_head still advances.
- Restore: head <= arch_head_next, where arch_head_next = arch_head + (retire_enable ? 1 : 0). Any alloc_req in the same cycle is dropped. Same-cycle retire push still occurs.
- Allocate + retire push same cycle: both apply; free_count unchanged. A PR pushed this cycle is not bypassed to alloc_pr; it is allocatable from the next cycle.
- No duplicate-free detection; upstream guarantees each PR is freed once.

## Timing
- Reset values: head=0, arch_head=0, tail=PHYS_REG_SZ-1; buf[i]=i+1 for i in 0..PHYS_REG_SZ-2; free_count=PHYS_REG_SZ-1; alloc_valid=1; alloc_pr=1; overflow_err=0.
- Reset mid-operation overrides all inputs in that cycle.
- alloc_pr/alloc_valid/free_count are combinational from registered state only (no input-to-output paths); the pop takes effect at the posedge sampling alloc_req, so the next PR appears the following cycle.
- Retire free: visible on alloc_pr/free_count one cycle after the retire edge.
- Restore: alloc_pr equals buf[arch_head_next] the cycle after the restore edge.
- Pointer wrap: slot index wraps modulo PHYS_REG_SZ; wrap bit distinguishes full from empty.

## Test plan
- Reset -> free_count=63, alloc_valid=1, alloc_pr=1, overflow_err=0.
- 63 back-to-back alloc_req -> alloc_pr sequence 1..63, then alloc_valid=0, free_count=0; 64th alloc_req ignored, head unchanged.
- From empty, retire_enable with retire_old_pr=5 -> next cycle alloc_valid=1, alloc_pr=5, free_count=1; retire with retire_old_pr=0 -> free_count unchanged.
- From reset: alloc 3 (PRs 1,2,3), retire 1 (old_pr=0), then restore_enable with alloc_req high -> next cycle alloc_pr=2, free_count=62, alloc dropped.
- Restore and retire (old_pr=0) same cycle after allocating 1,2 with no prior retire -> alloc_pr=2, free_count=62.
- Steady state alloc_req and retire_enable (old_pr=7) every cycle for 200 cycles -> free_count constant, pointers wrap, 7 reappears on alloc_pr after one full lap; overflow_err stays 0.
